// File: rtl/instr_fetch_unit_if.sv
// Handshake bundle between the fetch unit, instruction memory and the decode stage.
//   Imem*  : fetch request/acknowledge bus towards instruction memory
//   Id*    : valid/ready handshake plus instruction payload towards decode
// Modports:
//   master : the fetch unit side
//   slave  : the memory/decode environment side
interface instr_fetch_unit_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemData;
  logic        IdReady;
  logic        IdValid;
  logic [31:0] Instruction;
  logic [5:0]  OpCode;
  logic [31:0] PCPlus4;

  modport master (
    output ImemReq, ImemAddr, IdValid, Instruction, OpCode, PCPlus4,
    input  ImemAck, ImemData, IdReady
  );

  modport slave (
    input  ImemReq, ImemAddr, IdValid, Instruction, OpCode, PCPlus4,
    output ImemAck, ImemData, IdReady
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Upstream fetch stage of the single-issue MIPS datapath.
// Holds the PC, fetches words over a req/ack memory handshake and presents a registered
// instruction, OpCode and PC+4 to decode with a valid/ready handshake. A one-entry skid
// buffer absorbs a word returned while decode stalls; branch redirects are honoured even
// while a memory request is in flight (the in-flight word is drained and discarded).
// Ports:
//   Clk, Rst          : clock, synchronous active-high reset
//   Branch            : single-cycle redirect pulse
//   BranchTarget      : redirect address (bits [1:0] forced to 00)
//   bus (master)      : ImemReq/ImemAddr/ImemAck/ImemData memory bus,
//                       IdReady/IdValid/Instruction/OpCode/PCPlus4 decode handshake
//   FetchCount        : (IFU_PERF_CNT_EN only) instructions handed to decode
//   BubbleCount       : (IFU_PERF_CNT_EN only) cycles decode was ready but nothing valid
// Optional feature macro: IFU_PERF_CNT_EN adds the two performance counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  IDLE_OPCODE = 6'b111111
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Branch,
  input  logic [31:0] BranchTarget,
  instr_fetch_unit_if.master bus
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] BubbleCount
`endif
);

  typedef enum logic [1:0] {StFetch, StStall, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;

  logic [31:0] target;
  logic [31:0] pc_inc;
  logic        ack;
  logic        ready;

  assign target = BranchTarget & 32'hFFFF_FFFC;
  assign pc_inc = pc_q + 32'd4;  // wraps mod 2^32
  assign ack    = bus.ImemAck;
  assign ready  = bus.IdReady;

  // Memory-side outputs; request is suppressed while reset is held.
  always_comb begin
    bus.ImemReq  = 1'b0;
    bus.ImemAddr = pc_q;
    unique case (state_q)
      StFetch: begin
        bus.ImemReq  = !Rst;
        bus.ImemAddr = pc_q;
      end
      StDrain: begin
        bus.ImemReq  = !Rst;
        bus.ImemAddr = drain_addr_q;
      end
      StStall: begin
        bus.ImemReq  = 1'b0;
        bus.ImemAddr = pc_q;
      end
      default: begin
        bus.ImemReq  = 1'b0;
        bus.ImemAddr = pc_q;
      end
    endcase
  end

  assign bus.IdValid     = valid_q;
  assign bus.Instruction = instr_q;
  assign bus.OpCode      = valid_q ? instr_q[31:26] : IDLE_OPCODE;
  assign bus.PCPlus4     = pcplus4_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    instr_d      = instr_q;
    pcplus4_d    = pcplus4_q;
    valid_d      = valid_q;
    skid_d       = skid_q;
    skid_pc4_d   = skid_pc4_q;

    if (Branch) begin
      // Any presented word is consumed or dropped; skid contents are stale.
      valid_d    = 1'b0;
      skid_d     = '0;
      skid_pc4_d = '0;
      pc_d       = target;
      unique case (state_q)
        StFetch: begin
          if (!ack) begin
            drain_addr_d = pc_q;
            state_d      = StDrain;
          end
        end
        StStall: state_d = StFetch;
        // The drained request completing now means nothing is left in flight.
        StDrain: if (ack) state_d = StFetch;
        default: state_d = StFetch;
      endcase
    end else begin
      unique case (state_q)
        StFetch: begin
          if (ack) begin
            pc_d = pc_inc;
            if (!valid_q || ready) begin
              instr_d   = bus.ImemData;
              pcplus4_d = pc_inc;
              valid_d   = 1'b1;
            end else begin
              skid_d     = bus.ImemData;
              skid_pc4_d = pc_inc;
              state_d    = StStall;
            end
          end else if (ready) begin
            valid_d = 1'b0;
          end
        end
        StStall: begin
          if (ready) begin
            instr_d   = skid_q;
            pcplus4_d = skid_pc4_q;
            valid_d   = 1'b1;
            state_d   = StFetch;
          end
        end
        StDrain: begin
          if (ack) state_d = StFetch;
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      instr_q      <= '0;
      pcplus4_q    <= RESET_PC;
      valid_q      <= 1'b0;
      skid_q       <= '0;
      skid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      instr_q      <= instr_d;
      pcplus4_q    <= pcplus4_d;
      valid_q      <= valid_d;
      skid_q       <= skid_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (valid_q && ready)  fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (!valid_q && ready) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign FetchCount  = fetch_cnt_q;
  assign BubbleCount = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;
  logic        Clk;
  logic        Rst;
  logic        Branch;
  logic [31:0] BranchTarget;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] FetchCount;
  logic [31:0] BubbleCount;
`endif

  instr_fetch_unit_if bus_if ();

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IDLE_OPCODE(6'b111111)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Branch      (Branch),
    .BranchTarget(BranchTarget),
    .bus         (bus_if.master)
`ifdef IFU_PERF_CNT_EN
    ,
    .FetchCount  (FetchCount),
    .BubbleCount (BubbleCount)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock; sample 1ns after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic ack, input logic [31:0] data, input logic rdy);
    bus_if.ImemAck  = ack;
    bus_if.ImemData = data;
    bus_if.IdReady  = rdy;
  endtask

  initial begin
    Rst = 1'b1;
    Branch = 1'b0;
    BranchTarget = '0;
    drive(1'b0, '0, 1'b0);

    // Reset state
    tick();
    tick();
    check("rst_valid", 32'(bus_if.IdValid), 32'd0);
    check("rst_opcode", 32'(bus_if.OpCode), 32'h3F);
    check("rst_pcplus4", bus_if.PCPlus4, 32'h0);
    check("rst_instr", bus_if.Instruction, 32'h0);
    check("rst_req", 32'(bus_if.ImemReq), 32'd0);
    Rst = 1'b0;
    #1;
    check("first_req", 32'(bus_if.ImemReq), 32'd1);
    check("first_addr", bus_if.ImemAddr, 32'h0);

    // Back-to-back fetch
    drive(1'b1, 32'h2008_0005, 1'b1);
    tick();
    check("f1_valid", 32'(bus_if.IdValid), 32'd1);
    check("f1_instr", bus_if.Instruction, 32'h2008_0005);
    check("f1_opcode", 32'(bus_if.OpCode), 32'h08);
    check("f1_pc4", bus_if.PCPlus4, 32'h4);
    check("f1_addr", bus_if.ImemAddr, 32'h4);
    drive(1'b1, 32'h3109_00FF, 1'b1);
    tick();
    check("f2_opcode", 32'(bus_if.OpCode), 32'h0C);
    check("f2_pc4", bus_if.PCPlus4, 32'h8);
    check("f2_addr", bus_if.ImemAddr, 32'h8);

    // Backpressure: third word lands in the skid
    drive(1'b1, 32'h1111_1111, 1'b0);
    tick();
    check("stall_req", 32'(bus_if.ImemReq), 32'd0);
    check("stall_hold", bus_if.Instruction, 32'h3109_00FF);
    drive(1'b0, 32'h0, 1'b0);
    tick();
    tick();
    check("stall_req2", 32'(bus_if.ImemReq), 32'd0);
    check("stall_hold2", bus_if.Instruction, 32'h3109_00FF);
    check("stall_pc4", bus_if.PCPlus4, 32'h8);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    check("skid_instr", bus_if.Instruction, 32'h1111_1111);
    check("skid_pc4", bus_if.PCPlus4, 32'hC);
    check("skid_valid", 32'(bus_if.IdValid), 32'd1);
    check("skid_next_addr", bus_if.ImemAddr, 32'hC);
    drive(1'b1, 32'h2222_2222, 1'b1);
    tick();
    check("w4_instr", bus_if.Instruction, 32'h2222_2222);
    check("w4_pc4", bus_if.PCPlus4, 32'h10);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    check("bubble_valid", 32'(bus_if.IdValid), 32'd0);
    check("bubble_opcode", 32'(bus_if.OpCode), 32'h3F);

    // Branch while request to 0x10 is outstanding; ack comes 3 cycles later
    Branch = 1'b1;
    BranchTarget = 32'h0000_0100;
    drive(1'b0, 32'h0, 1'b1);
    tick();
    Branch = 1'b0;
    check("drain_addr0", bus_if.ImemAddr, 32'h10);
    check("drain_req0", 32'(bus_if.ImemReq), 32'd1);
    check("drain_valid0", 32'(bus_if.IdValid), 32'd0);
    tick();
    check("drain_addr1", bus_if.ImemAddr, 32'h10);
    drive(1'b1, 32'hDEAD_BEEF, 1'b1);
    tick();
    check("drain_discard", 32'(bus_if.IdValid), 32'd0);
    check("redirect_addr", bus_if.ImemAddr, 32'h100);
    drive(1'b1, 32'h8C00_0100, 1'b1);
    tick();
    check("tgt_valid", 32'(bus_if.IdValid), 32'd1);
    check("tgt_opcode", 32'(bus_if.OpCode), 32'h23);
    check("tgt_pc4", bus_if.PCPlus4, 32'h104);

    // Branch coincident with ack, unaligned target
    Branch = 1'b1;
    BranchTarget = 32'h0000_0203;
    drive(1'b1, 32'hAAAA_AAAA, 1'b1);
    tick();
    Branch = 1'b0;
    check("bra_ack_valid", 32'(bus_if.IdValid), 32'd0);
    check("bra_ack_addr", bus_if.ImemAddr, 32'h200);

    // Enter STALL, then reset in the middle of it
    drive(1'b1, 32'h0C00_0001, 1'b1);
    tick();
    check("pre_stall_pc4", bus_if.PCPlus4, 32'h204);
    drive(1'b1, 32'h0C00_0002, 1'b0);
    tick();
    check("pre_rst_req", 32'(bus_if.ImemReq), 32'd0);
    Rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    tick();
    check("midrst_valid", 32'(bus_if.IdValid), 32'd0);
    check("midrst_opcode", 32'(bus_if.OpCode), 32'h3F);
    check("midrst_pc4", bus_if.PCPlus4, 32'h0);
    Rst = 1'b0;
    #1;
    check("postrst_addr", bus_if.ImemAddr, 32'h0);
    check("postrst_req", 32'(bus_if.ImemReq), 32'd1);

    // PC wrap: redirect to the last word, then fetch it
    Branch = 1'b1;
    BranchTarget = 32'hFFFF_FFFC;
    drive(1'b1, 32'h0, 1'b1);
    tick();
    Branch = 1'b0;
    check("wrap_addr0", bus_if.ImemAddr, 32'hFFFF_FFFC);
    drive(1'b1, 32'h1234_5678, 1'b1);
    tick();
    check("wrap_pc4", bus_if.PCPlus4, 32'h0);
    check("wrap_addr1", bus_if.ImemAddr, 32'h0);

`ifdef IFU_PERF_CNT_EN
    // 5 delivered, 2 bubble cycles
    Rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    tick();
    Rst = 1'b0;
    check("cnt_rst_fetch", FetchCount, 32'd0);
    check("cnt_rst_bubble", BubbleCount, 32'd0);
    drive(1'b1, 32'h0000_0001, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0000_0002 + 32'(i), 1'b1);
      tick();
    end
    drive(1'b0, 32'h0, 1'b1);
    tick();
    tick();
    tick();
    drive(1'b0, 32'h0, 1'b0);
    check("cnt_fetch", FetchCount, 32'd5);
    check("cnt_bubble", BubbleCount, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
